// File: rtl/rob_param_pkg.sv
// Shared definitions for the reorder buffer: opcode map, opcode class struct,
// data widths and a tag-width helper.
package rob_param_pkg;

  localparam int OPC_W = 6;
  localparam int REG_W = 5;
  localparam int XLEN  = 32;

  // Opcode map. Each class occupies one contiguous range so that a class
  // can be decoded with a single range compare.
  localparam logic [OPC_W-1:0]
    OP_NOP  = 6'd0,  OP_ADD  = 6'd1,  OP_SUB  = 6'd2,  OP_ADDI = 6'd3,
    OP_LUI  = 6'd4,  OP_JAL  = 6'd5,  OP_JALR = 6'd6,
    OP_BEQ  = 6'd8,  OP_BNE  = 6'd9,  OP_BLT  = 6'd10, OP_BGE  = 6'd11,
    OP_BLTU = 6'd12, OP_BGEU = 6'd13,
    OP_LB   = 6'd16, OP_LH   = 6'd17, OP_LW   = 6'd18, OP_LBU  = 6'd19,
    OP_LHU  = 6'd20,
    OP_SB   = 6'd24, OP_SH   = 6'd25, OP_SW   = 6'd26;

  typedef struct packed {
    logic is_branch;
    logic is_store;
    logic is_load;
    logic is_jalr;
  } op_class_t;

  function automatic int tag_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/rob_param_if.sv
// Bundle of all ROB-facing buses: dispatcher issue, writeback channels,
// operand query, commit, store handshake, flush and predictor update.
//   slave  : the ROB side
//   master : the surrounding core (dispatcher / ALU / LSB / RF)
interface rob_param_if #(
  parameter int DEPTH  = 16,
  parameter int TAG_W  = 4,
  parameter int NUM_WB = 2
);
  import rob_param_pkg::*;

  // issue
  logic                               issue_en;
  logic [OPC_W-1:0]                   issue_opcode;
  logic [REG_W-1:0]                   issue_rd;
  logic [REG_W-1:0]                   issue_pre_reg;
  logic                               issue_pre_br;
  logic [TAG_W-1:0]                   free_rob_id;
  logic                               full;
  logic [TAG_W:0]                     count;
  // writeback, channel 0 in the LSBs
  logic [NUM_WB-1:0]                  wb_en;
  logic [NUM_WB-1:0][TAG_W-1:0]       wb_id;
  logic [NUM_WB-1:0][XLEN-1:0]        wb_val;
  logic [NUM_WB-1:0][XLEN-1:0]        wb_pc;
  logic [NUM_WB-1:0]                  wb_taken;
  // operand query
  logic [TAG_W-1:0]                   qry_id;
  logic                               qry_rdy;
  logic [XLEN-1:0]                    qry_val;
  // commit
  logic                               commit_en;
  logic [TAG_W-1:0]                   commit_tag;
  logic [REG_W-1:0]                   commit_rd;
  logic [XLEN-1:0]                    commit_val;
  // store handshake
  logic                               store_req;
  logic                               store_ack;
  // redirect / predictor
  logic                               flush;
  logic [XLEN-1:0]                    new_pc;
  logic                               pre_upt_en;
  logic [REG_W-1:0]                   pre_upt_reg;
  logic                               pre_upt_taken;

  modport slave (
    input  issue_en, issue_opcode, issue_rd, issue_pre_reg, issue_pre_br,
    output free_rob_id, full, count,
    input  wb_en, wb_id, wb_val, wb_pc, wb_taken,
    input  qry_id,
    output qry_rdy, qry_val,
    output commit_en, commit_tag, commit_rd, commit_val,
    output store_req,
    input  store_ack,
    output flush, new_pc, pre_upt_en, pre_upt_reg, pre_upt_taken
  );

  modport master (
    output issue_en, issue_opcode, issue_rd, issue_pre_reg, issue_pre_br,
    input  free_rob_id, full, count,
    output wb_en, wb_id, wb_val, wb_pc, wb_taken,
    output qry_id,
    input  qry_rdy, qry_val,
    input  commit_en, commit_tag, commit_rd, commit_val,
    input  store_req,
    output store_ack,
    input  flush, new_pc, pre_upt_en, pre_upt_reg, pre_upt_taken
  );

endinterface

// File: rtl/rob_param_op_class.sv
// Combinational opcode classifier.
//   opcode_i : opcode of the entry being examined
//   cls_o    : branch / store / load / jalr flags
module rob_param_op_class
  import rob_param_pkg::*;
(
  input  logic [OPC_W-1:0] opcode_i,
  output op_class_t        cls_o
);

  assign cls_o.is_branch = (opcode_i >= OP_BEQ) && (opcode_i <= OP_BGEU);
  assign cls_o.is_store  = (opcode_i >= OP_SB)  && (opcode_i <= OP_SW);
  assign cls_o.is_load   = (opcode_i >= OP_LB)  && (opcode_i <= OP_LHU);
  assign cls_o.is_jalr   = (opcode_i == OP_JALR);

endmodule

// File: rtl/rob_param.sv
// Parametrised reorder buffer. Allocates entries in program order at the
// tail, accepts out-of-order results on NUM_WB writeback channels and
// retires at most one entry per cycle from the head. Stores retire only
// after the LSB acknowledges; mispredicted branches and JALR raise a
// one-cycle flush that empties the buffer on the following edge.
//   clk, rst_n : clock, async active-low reset
//   rdy        : global enable, 0 freezes all state
//   bus        : rob_param_if.slave (issue / wb / query / commit / store /
//                flush / predictor update)
module rob_param
  import rob_param_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int TAG_W       = 4,
  parameter int NUM_WB      = 2,
  parameter int FULL_MARGIN = 1
)(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rdy,
  rob_param_if.slave  bus
);

  localparam int CW = TAG_W + 1;

  // pointers and occupancy
  logic [TAG_W-1:0]              head_q, tail_q;
  logic [CW-1:0]                 count_q;
  // entry arrays
  logic [DEPTH-1:0]              busy_q, ready_q, pre_br_q, taken_q;
  logic [DEPTH-1:0][OPC_W-1:0]   opc_q;
  logic [DEPTH-1:0][REG_W-1:0]   rd_q, pre_reg_q;
  logic [DEPTH-1:0][XLEN-1:0]    val_q, pc_q;
  // registered outputs
  logic                          commit_en_q, flush_q, pre_upt_en_q;
  logic                          store_req_q, pre_upt_taken_q;
  logic [TAG_W-1:0]              commit_tag_q;
  logic [REG_W-1:0]              commit_rd_q, pre_upt_reg_q;
  logic [XLEN-1:0]               commit_val_q, new_pc_q;

  op_class_t hcls;
  logic      unused_cls;

  rob_param_op_class u_cls (
    .opcode_i (opc_q[head_q]),
    .cls_o    (hcls)
  );
  assign unused_cls = hcls.is_load;

  // per-channel, per-entry writeback hits; ids of idle entries are dropped
  logic [NUM_WB-1:0][DEPTH-1:0] wb_hit;
  for (genvar k = 0; k < NUM_WB; k++) begin : g_wb
    for (genvar e = 0; e < DEPTH; e++) begin : g_ent
      assign wb_hit[k][e] = bus.wb_en[k] && (bus.wb_id[k] == TAG_W'(e)) && busy_q[e];
    end
  end

  logic head_busy, retire_alu, retire_st, retire, do_issue;

  assign head_busy  = busy_q[head_q];
  assign retire_alu = rdy && !flush_q && head_busy && ready_q[head_q] && !hcls.is_store;
  // a store leaves only on the edge its acknowledged request is seen
  assign retire_st  = rdy && !flush_q && head_busy && hcls.is_store && store_req_q && bus.store_ack;
  assign retire     = retire_alu || retire_st;
  assign do_issue   = rdy && !flush_q && bus.issue_en && (count_q != CW'(DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q          <= '0;
      tail_q          <= '0;
      count_q         <= '0;
      busy_q          <= '0;
      ready_q         <= '0;
      pre_br_q        <= '0;
      taken_q         <= '0;
      opc_q           <= '0;
      rd_q            <= '0;
      pre_reg_q       <= '0;
      val_q           <= '0;
      pc_q            <= '0;
      commit_en_q     <= 1'b0;
      commit_tag_q    <= '0;
      commit_rd_q     <= '0;
      commit_val_q    <= '0;
      store_req_q     <= 1'b0;
      flush_q         <= 1'b0;
      new_pc_q        <= '0;
      pre_upt_en_q    <= 1'b0;
      pre_upt_reg_q   <= '0;
      pre_upt_taken_q <= 1'b0;
    end else if (flush_q) begin
      // Consumers already acted on the flush pulse, so the buffer empties
      // on this edge even if rdy has dropped; otherwise ROB and consumers
      // would disagree about what is in flight.
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      busy_q       <= '0;
      ready_q      <= '0;
      store_req_q  <= 1'b0;
      commit_en_q  <= 1'b0;
      flush_q      <= 1'b0;
      pre_upt_en_q <= 1'b0;
    end else if (rdy) begin
      commit_en_q  <= 1'b0;
      pre_upt_en_q <= 1'b0;

      // ascending channel order: the highest channel wins on a shared id
      for (int e = 0; e < DEPTH; e++) begin
        for (int k = 0; k < NUM_WB; k++) begin
          if (wb_hit[k][e]) begin
            ready_q[e] <= 1'b1;
            val_q[e]   <= bus.wb_val[k];
            pc_q[e]    <= bus.wb_pc[k];
            taken_q[e] <= bus.wb_taken[k];
          end
        end
      end

      if (do_issue) begin
        busy_q[tail_q]    <= 1'b1;
        ready_q[tail_q]   <= 1'b0;
        opc_q[tail_q]     <= bus.issue_opcode;
        rd_q[tail_q]      <= bus.issue_rd;
        pre_reg_q[tail_q] <= bus.issue_pre_reg;
        pre_br_q[tail_q]  <= bus.issue_pre_br;
        tail_q            <= tail_q + TAG_W'(1);
      end

      if (retire) begin
        busy_q[head_q]  <= 1'b0;
        ready_q[head_q] <= 1'b0;
        head_q          <= head_q + TAG_W'(1);
        commit_en_q     <= 1'b1;
        commit_tag_q    <= head_q;
        commit_rd_q     <= rd_q[head_q];
        commit_val_q    <= val_q[head_q];
        if (hcls.is_branch) begin
          pre_upt_en_q    <= 1'b1;
          pre_upt_reg_q   <= pre_reg_q[head_q];
          pre_upt_taken_q <= taken_q[head_q];
          new_pc_q        <= pc_q[head_q];
          flush_q         <= taken_q[head_q] != pre_br_q[head_q];
        end else if (hcls.is_jalr) begin
          new_pc_q <= pc_q[head_q];
          flush_q  <= 1'b1;
        end
      end

      count_q     <= count_q + CW'(do_issue) - CW'(retire);
      store_req_q <= head_busy && hcls.is_store && !retire_st;
    end else begin
      commit_en_q  <= 1'b0;
      flush_q      <= 1'b0;
      pre_upt_en_q <= 1'b0;
    end
  end

  assign bus.free_rob_id   = tail_q;
  assign bus.count         = count_q;
  assign bus.full          = count_q >= CW'(DEPTH - FULL_MARGIN);
  assign bus.qry_rdy       = ready_q[bus.qry_id];
  assign bus.qry_val       = val_q[bus.qry_id];
  assign bus.commit_en     = commit_en_q;
  assign bus.commit_tag    = commit_tag_q;
  assign bus.commit_rd     = commit_rd_q;
  assign bus.commit_val    = commit_val_q;
  assign bus.store_req     = store_req_q;
  assign bus.flush         = flush_q;
  assign bus.new_pc        = new_pc_q;
  assign bus.pre_upt_en    = pre_upt_en_q;
  assign bus.pre_upt_reg   = pre_upt_reg_q;
  assign bus.pre_upt_taken = pre_upt_taken_q;

endmodule
